// File: rtl/calc_ctrl_if.sv
// Handshake and ALU bundle between the calculator controller and its environment.
// The keypad and ALU sides drive the master modport; the controller uses the slave modport.
interface calc_ctrl_if;
    logic       IN_key_valid;
    logic [3:0] IN_key_code;
    logic [7:0] IN_alu_S;
    logic       IN_alu_zero;
    logic       IN_alu_carry_out;
    logic [3:0] OUT_alu_CS;
    logic [7:0] OUT_alu_a;
    logic [7:0] OUT_alu_b;
    logic       OUT_alu_carry_in;
    logic [7:0] OUT_result;
    logic       OUT_result_valid;
    logic       OUT_flag_zero;
    logic       OUT_flag_carry;
    logic [7:0] OUT_display;
    logic       OUT_busy;

    modport master (
        output IN_key_valid, IN_key_code,
        output IN_alu_S, IN_alu_zero, IN_alu_carry_out,
        input  OUT_alu_CS, OUT_alu_a, OUT_alu_b, OUT_alu_carry_in,
        input  OUT_result, OUT_result_valid,
        input  OUT_flag_zero, OUT_flag_carry,
        input  OUT_display, OUT_busy
    );

    modport slave (
        input  IN_key_valid, IN_key_code,
        input  IN_alu_S, IN_alu_zero, IN_alu_carry_out,
        output OUT_alu_CS, OUT_alu_a, OUT_alu_b, OUT_alu_carry_in,
        output OUT_result, OUT_result_valid,
        output OUT_flag_zero, OUT_flag_carry,
        output OUT_display, OUT_busy
    );
endinterface

// File: rtl/calc_ctrl.sv
// Keypad calculator controller driving an external 8-bit ALU.
// Define CALC_CARRY_CHAIN_EN to feed the previous carry into chained add/sub/cmp.
module calc_ctrl (
    input logic        IN_clk,
    input logic        IN_rst,
    calc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ENTER_A, ENTER_B, EXEC, SHOW} state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_a, w_a_nxt;
    logic [7:0] r_b, w_b_nxt;
    logic [3:0] r_op, w_op_nxt;
    logic [7:0] r_result;
    logic       r_zero;
    logic       r_carry;
    logic       r_valid;
`ifdef CALC_CARRY_CHAIN_EN
    logic       r_chain, w_chain_nxt;
`endif

    logic        w_key;
    logic [3:0]  w_code;
    logic        w_digit, w_oper, w_equal;
    logic [11:0] w_acc_a, w_acc_b;
    logic        w_cin;

    assign w_key   = bus.IN_key_valid;
    assign w_code  = bus.IN_key_code;
    assign w_digit = w_code <= 4'h9;
    assign w_oper  = (w_code >= 4'hA) && (w_code <= 4'hE);
    assign w_equal = w_code == 4'hF;

    // operand*10 + digit, wide enough to detect overflow past 255
    assign w_acc_a = ({4'd0, r_a} << 3) + ({4'd0, r_a} << 1) + {8'd0, w_code};
    assign w_acc_b = ({4'd0, r_b} << 3) + ({4'd0, r_b} << 1) + {8'd0, w_code};

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
`ifdef CALC_CARRY_CHAIN_EN
        w_chain_nxt = r_chain;
`endif
        unique case (r_state)
            ENTER_A: begin
                if (w_key && w_digit && (w_acc_a <= 12'd255)) begin
                    w_a_nxt = w_acc_a[7:0];
                end else if (w_key && w_oper) begin
                    w_op_nxt    = w_code;
                    w_b_nxt     = 8'd0;
                    w_state_nxt = ENTER_B;
                end
            end
            ENTER_B: begin
                if (w_key && w_digit && (w_acc_b <= 12'd255)) begin
                    w_b_nxt = w_acc_b[7:0];
                end else if (w_key && w_oper) begin
                    w_op_nxt = w_code;
                end else if (w_key && w_equal) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = SHOW;
            end
            SHOW: begin
                if (w_key && w_digit) begin
                    w_a_nxt     = {4'd0, w_code};
`ifdef CALC_CARRY_CHAIN_EN
                    w_chain_nxt = 1'b0;
`endif
                    w_state_nxt = ENTER_A;
                end else if (w_key && w_oper) begin
                    w_a_nxt     = r_result;
`ifdef CALC_CARRY_CHAIN_EN
                    w_chain_nxt = 1'b1;
`endif
                    w_op_nxt    = w_code;
                    w_b_nxt     = 8'd0;
                    w_state_nxt = ENTER_B;
                end
            end
            default: w_state_nxt = ENTER_A;
        endcase
    end

    always_comb begin
        w_cin = (r_op == 4'hB) || (r_op == 4'hE);
`ifdef CALC_CARRY_CHAIN_EN
        if (r_chain && ((r_op == 4'hA) || (r_op == 4'hB) || (r_op == 4'hE))) begin
            w_cin = r_carry;
        end
`endif
    end

    always_ff @(posedge IN_clk) begin
        if (IN_rst) begin
            r_state  <= ENTER_A;
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_op     <= 4'hA;
            r_result <= 8'd0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_valid  <= 1'b0;
`ifdef CALC_CARRY_CHAIN_EN
            r_chain  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_op    <= w_op_nxt;
            r_valid <= r_state == EXEC;
`ifdef CALC_CARRY_CHAIN_EN
            r_chain <= w_chain_nxt;
`endif
            if (r_state == EXEC) begin
                r_result <= bus.IN_alu_S;
                r_zero   <= bus.IN_alu_zero;
                r_carry  <= bus.IN_alu_carry_out;
            end
        end
    end

    assign bus.OUT_alu_CS       = (r_state == EXEC) ? r_op : 4'h0;
    assign bus.OUT_alu_a        = r_a;
    assign bus.OUT_alu_b        = r_b;
    assign bus.OUT_alu_carry_in = (r_state == EXEC) && w_cin;
    assign bus.OUT_result       = r_result;
    assign bus.OUT_result_valid = r_valid;
    assign bus.OUT_flag_zero    = r_zero;
    assign bus.OUT_flag_carry   = r_carry;
    assign bus.OUT_busy         = r_state == EXEC;

    always_comb begin
        bus.OUT_display = r_result;
        unique case (r_state)
            ENTER_A: bus.OUT_display = r_a;
            ENTER_B: bus.OUT_display = r_b;
            default: bus.OUT_display = r_result;
        endcase
    end
endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: keypad stimulus, behavioural ALU and calculator model.
// Honours CALC_CARRY_CHAIN_EN the same way the design does.
module tb_calc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc_ctrl_if bus ();

    calc_ctrl dut (
        .IN_clk (clk),
        .IN_rst (rst),
        .bus    (bus)
    );

`ifdef CALC_CARRY_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    // External ALU: ripple adder with optional operand inversion
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum              = 9'd0;
        bus.IN_alu_S         = 8'd0;
        bus.IN_alu_carry_out = 1'b0;
        case (bus.OUT_alu_CS)
            4'hA: begin
                alu_sum = {1'b0, bus.OUT_alu_a} + {1'b0, bus.OUT_alu_b}
                        + {8'd0, bus.OUT_alu_carry_in};
                bus.IN_alu_S         = alu_sum[7:0];
                bus.IN_alu_carry_out = alu_sum[8];
            end
            4'hB, 4'hE: begin
                alu_sum = {1'b0, bus.OUT_alu_a} + {1'b0, ~bus.OUT_alu_b}
                        + {8'd0, bus.OUT_alu_carry_in};
                bus.IN_alu_S         = alu_sum[7:0];
                bus.IN_alu_carry_out = (bus.OUT_alu_CS == 4'hE) ? ~alu_sum[8] : alu_sum[8];
            end
            4'hC: bus.IN_alu_S = bus.OUT_alu_a & bus.OUT_alu_b;
            4'hD: bus.IN_alu_S = bus.OUT_alu_a | bus.OUT_alu_b;
            default: ;
        endcase
        bus.IN_alu_zero = bus.IN_alu_S == 8'd0;
    end

    typedef struct {
        int res;
        int z;
        int c;
        int due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t m_pend;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ncyc  = 0;

    // Calculator model: mode 0 = typing A, 1 = typing B, 2 = showing result
    int m_a, m_b, m_op, m_res, m_z, m_c, m_chain, m_mode, m_exec;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    function automatic void model_reset();
        m_a = 0; m_b = 0; m_op = 10; m_res = 0; m_z = 0; m_c = 0;
        m_chain = 0; m_mode = 0; m_exec = 0;
    endfunction

    function automatic void model_compute();
        int cin, s, d, r, c;
        if (CHAIN && m_chain != 0 && (m_op == 10 || m_op == 11 || m_op == 14))
            cin = m_c;
        else
            cin = (m_op == 11 || m_op == 14) ? 1 : 0;
        r = 0; c = 0;
        case (m_op)
            10: begin s = m_a + m_b + cin; r = s % 256; c = (s > 255) ? 1 : 0; end
            11: begin d = m_a - m_b - (1 - cin); r = (d + 256) % 256; c = (d >= 0) ? 1 : 0; end
            14: begin d = m_a - m_b - (1 - cin); r = (d + 256) % 256; c = (d < 0) ? 1 : 0; end
            12: r = m_a & m_b;
            13: r = m_a | m_b;
            default: ;
        endcase
        m_pend.res = r;
        m_pend.z   = (r == 0) ? 1 : 0;
        m_pend.c   = c;
        m_pend.due = ncyc + 1;
    endfunction

    function automatic void model_edge(input bit v, input int k);
        if (m_exec != 0) begin
            m_res = m_pend.res; m_z = m_pend.z; m_c = m_pend.c;
            m_exec = 0; m_mode = 2;
            return;
        end
        if (!v) return;
        if (k <= 9) begin
            if (m_mode == 2) begin
                m_a = k; m_chain = 0; m_mode = 0;
            end else if (m_mode == 0) begin
                if (m_a * 10 + k <= 255) m_a = m_a * 10 + k;
            end else begin
                if (m_b * 10 + k <= 255) m_b = m_b * 10 + k;
            end
        end else if (k <= 14) begin
            if (m_mode == 2) begin
                m_a = m_res; m_chain = 1;
            end
            if (m_mode != 1) m_b = 0;
            m_op = k; m_mode = 1;
        end else if (m_mode == 1) begin
            model_compute();
            q.push_back(m_pend);
            m_exec = 1;
        end
    endfunction

    function automatic int exp_disp();
        if (m_exec != 0 || m_mode == 2) return m_res;
        return (m_mode == 0) ? m_a : m_b;
    endfunction

    task automatic idle();
        @(posedge clk);
        ncyc++;
        model_edge(1'b0, 0);
        @(negedge clk);
    endtask

    task automatic press(input int k, input int gap);
        bus.IN_key_valid = 1'b1;
        bus.IN_key_code  = 4'(k);
        @(posedge clk);
        ncyc++;
        model_edge(1'b1, k);
        @(negedge clk);
        bus.IN_key_valid = 1'b0;
        chk("display", int'(bus.OUT_display), exp_disp());
        chk("busy", int'(bus.OUT_busy), m_exec);
        repeat (gap) idle();
    endtask

    task automatic run(input int ks[$], input int gap);
        foreach (ks[i]) press(ks[i], gap);
    endtask

    task automatic do_reset(input bit with_key);
        rst = 1'b1;
        bus.IN_key_valid = with_key;
        bus.IN_key_code  = 4'h5;
        @(posedge clk);
        ncyc++;
        if (m_exec != 0) void'(q.pop_back());
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.IN_key_valid = 1'b0;
        chk("rst_result", int'(bus.OUT_result), 0);
        chk("rst_display", int'(bus.OUT_display), 0);
        chk("rst_busy", int'(bus.OUT_busy), 0);
        chk("rst_valid", int'(bus.OUT_result_valid), 0);
        chk("rst_flags", int'({bus.OUT_flag_zero, bus.OUT_flag_carry}), 0);
        chk("rst_alu_a", int'(bus.OUT_alu_a), 0);
    endtask

    // Monitor: every result pulse must match the oldest expected result
    always @(negedge clk) begin
        if (bus.OUT_result_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL valid_pulse: unexpected pulse, result %0d expected none",
                         bus.OUT_result);
            end else begin
                mon_e = q.pop_front();
                chk("sb_result", int'(bus.OUT_result), mon_e.res);
                chk("sb_zero", int'(bus.OUT_flag_zero), mon_e.z);
                chk("sb_carry", int'(bus.OUT_flag_carry), mon_e.c);
                chk("sb_latency", ncyc, mon_e.due);
            end
        end
        if (bus.OUT_busy === 1'b0) chk("cs_idle", int'(bus.OUT_alu_CS), 0);
    end

    int s[$];
    int r, k;
    int exp031;

    initial begin
        bus.IN_key_valid = 1'b0;
        bus.IN_key_code  = 4'h0;
        model_reset();
        @(negedge clk);
        do_reset(1'b1);

        s = '{1, 2, 10, 3, 4, 15};
        run(s, 1);
        repeat (2) idle();
        chk("r030_result", int'(bus.OUT_result), 46);
        chk("r030_flags", int'({bus.OUT_flag_zero, bus.OUT_flag_carry}), 0);

        do_reset(1'b0);
        s = '{2, 0, 0, 10, 1, 0, 0, 15};
        run(s, 1);
        repeat (2) idle();
        chk("r031_result", int'(bus.OUT_result), 44);
        chk("r031_carry", int'(bus.OUT_flag_carry), 1);
        s = '{10, 1, 15};
        run(s, 1);
        repeat (2) idle();
        exp031 = CHAIN ? 46 : 45;
        chk("r031_chain", int'(bus.OUT_result), exp031);

        do_reset(1'b0);
        s = '{5, 11, 7, 15};
        run(s, 2);
        chk("r032_sub", int'(bus.OUT_result), 254);
        chk("r032_sub_c", int'(bus.OUT_flag_carry), 0);
        s = '{3, 14, 3, 15};
        run(s, 2);
        chk("r032_cmp_eq", int'({bus.OUT_result, bus.OUT_flag_zero, bus.OUT_flag_carry}),
            int'({8'd0, 1'b1, 1'b0}));
        s = '{5, 14, 7, 15};
        run(s, 2);
        chk("r032_cmp_lt", int'(bus.OUT_flag_carry), 1);

        do_reset(1'b0);
        s = '{2, 5};
        run(s, 0);
        chk("r033_25", int'(bus.OUT_display), 25);
        press(5, 0);
        chk("r033_255", int'(bus.OUT_display), 255);
        press(1, 0);
        chk("r033_hold", int'(bus.OUT_display), 255);

        do_reset(1'b0);
        s = '{9, 10, 12, 1};
        run(s, 1);
        press(15, 0);
        press(7, 2);
        chk("r034_and", int'(bus.OUT_result), 1);
        chk("r034_drop", int'(bus.OUT_display), 1);
        s = '{2, 10, 3};
        run(s, 1);
        press(15, 0);
        do_reset(1'b1);
        repeat (3) idle();
        chk("r034_rst_exec", int'(bus.OUT_result), 0);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset(r == 0);
            end else begin
                if (r < 60) k = int'($urandom_range(0, 9));
                else if (r < 85) k = int'($urandom_range(10, 14));
                else k = 15;
                press(k, int'($urandom_range(0, 2)));
            end
        end

        repeat (4) idle();
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL: IN_clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: IN_rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: IN_key_valid  input  1  one-cycle pulse, key press present.
REQ-004 SHALL: IN_key_code  input  4  0x0-0x9 digit; 0xA add; 0xB sub; 0xC and; 0xD or; 0xE cmp; 0xF equals.
REQ-005 SHALL: IN_alu_S  input  8  ALU result.
REQ-006 SHALL: IN_alu_zero  input  1  ALU zero flag.
REQ-007 SHALL: IN_alu_carry_out  input  1  ALU carry/borrow/less flag.
REQ-008 SHALL: OUT_alu_CS  output  4  ALU op select; 0x0 when not in EXEC.
REQ-009 SHALL: OUT_alu_a, OUT_alu_b  output  8 each  ALU operands.
REQ-010 SHALL: OUT_alu_carry_in  output  1  ALU carry input.
REQ-011 SHALL: OUT_result  output  8  latched result; OUT_result_valid  output  1  one-cycle pulse.
REQ-012 SHALL: OUT_flag_zero, OUT_flag_carry  output  1 each  latched ALU flags.
REQ-013 SHALL: OUT_display  output  8  value to show; OUT_busy  output  1  high in EXEC.

Function
REQ-014 SHALL: FSM states ENTER_A, ENTER_B, EXEC, SHOW; one transition per accepted key.
REQ-015 SHALL: Digit d in ENTER_A/ENTER_B: operand = operand*10+d if result <= 255, else digit ignored, operand held.
REQ-016 SHALL: Operator (0xA-0xE) in ENTER_A: latch op, B=0, go ENTER_B.
REQ-017 SHALL: Operator in ENTER_B: replace latched op (last wins), B unchanged, stay.
REQ-018 SHALL: 0xF in ENTER_A ignored; 0xF in ENTER_B: go EXEC (B may be 0).
REQ-019 SHALL: EXEC lasts exactly one cycle: OUT_alu_CS=op, OUT_alu_a=A, OUT_alu_b=B; IN_alu_S/zero/carry_out registered into OUT_result/flags at that edge; go SHOW.
REQ-020 SHALL: OUT_result_valid pulses high the first SHOW cycle only (latency: 0xF accepted at edge N, valid high cycle N+2).
REQ-021 SHALL: In SHOW: digit clears A, A=digit, go ENTER_A; operator sets A=OUT_result, marks A as chained, latches op, B=0, go ENTER_B; 0xF ignored.
REQ-022 SHALL: IN_key_valid during EXEC ignored (key dropped, no queue).
REQ-023 SHALL: Default carry_in: 0 for 0xA, 1 for 0xB/0xE (no borrow), 0 for 0xC/0xD.
REQ-024 SHALL: OUT_display = A in ENTER_A, B in ENTER_B, OUT_result in EXEC/SHOW.
REQ-025 SHALL: Key codes outside valid decode impossible (4-bit full map); no error state.

Reset
REQ-026 SHALL: IN_rst high at edge: state ENTER_A, A=B=0, op=0xA, chained=0, all outputs 0, including mid-EXEC (no result latched, no valid pulse).
REQ-027 SHALL: IN_key_valid in the reset cycle ignored.

Configuration
REQ-028 SHALL: Macro CALC_CARRY_CHAIN_EN defined: when A is chained (REQ-021) and op is 0xA/0xB/0xE, OUT_alu_carry_in = OUT_flag_carry; otherwise REQ-023.
REQ-029 SHALL: Macro undefined: OUT_alu_carry_in always per REQ-023; chained flag unused.

Verification
REQ-030 SHALL: keys 1,2,A,3,4,F -> OUT_result=46, zero=0, carry=0, valid 1 cycle.
REQ-031 SHALL: keys 2,0,0,A,1,0,0,F -> result=44, carry=1; then A,1,F -> 46 with CALC_CARRY_CHAIN_EN, 45 without.
REQ-032 SHALL: keys 5,B,7,F -> result=254, carry=0; keys 3,E,3,F -> result=0, zero=1, carry=0; keys 5,E,7,F -> carry=1.
REQ-033 SHALL: keys 2,5,6 -> OUT_display=25; then 5 -> 255; then 1 -> 255 held.
REQ-034 SHALL: keys 9,A,C,1,F -> op=and, result=1; key pulse during EXEC dropped; IN_rst during EXEC -> state ENTER_A, OUT_result=0, no valid pulse.
